ram16x4: RTL and testbench



---
 rtl/ram16x4.sv | 41 ++++
 tb/tb_ram16x4.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ram16x4.sv
// 16-word x 4-bit synchronous single-port RAM with registered read data.
// Optional build macro RAM16X4_WRITE_THROUGH_EN copies write data to data_out on write edges.
module ram16x4 #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              csn,
    input  logic              rwn
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // The whole array lives in resettable flops so an async reset clears every word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
        end else if (!csn) begin
            if (!rwn) begin
                mem[addr] <= data_in;
`ifdef RAM16X4_WRITE_THROUGH_EN
                data_out  <= data_in;
`else
                data_out  <= data_out;
`endif
            end else begin
                data_out <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_ram16x4.sv
// Self-checking bench for ram16x4: vector table plus scoreboarded hand sequences.
module tb_ram16x4;

    logic       clk;
    logic       rst;
    logic [3:0] data_out;
    logic [3:0] data_in;
    logic [3:0] addr;
    logic       csn;
    logic       rwn;

    int vectors  = 0;
    int failures = 0;

    typedef struct {
        logic       csn;
        logic       rwn;
        logic [3:0] addr;
        logic [3:0] din;
        logic [3:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } sb_t;

    vec_t       vecs [10];
    sb_t        sb_q [$];
    logic [3:0] model_mem [16];
    logic [3:0] model_out;

    ram16x4 #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_out (data_out),
        .data_in  (data_in),
        .addr     (addr),
        .csn      (csn),
        .rwn      (rwn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: data_out=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        sb_t e;
        if (sb_q.size() == 0) begin
            vectors++;
            failures++;
            $display("[TB] FAIL scoreboard: empty queue, data_out=%h expected=entry", data_out);
        end else begin
            e = sb_q.pop_front();
            compare(e.name, data_out, e.exp);
        end
    endtask

    // Drive one cycle, push the expected post-edge output, then check it after the edge.
    task automatic applyStimulus(input logic c, input logic r, input logic [3:0] a,
                                 input logic [3:0] d, input logic [3:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        csn     = c;
        rwn     = r;
        addr    = a;
        data_in = d;
        e.exp   = exp;
`ifdef RAM16X4_WRITE_THROUGH_EN
        if (!c && !r) e.exp = d;
`endif
        e.name = name;
        sb_q.push_back(e);
        if (!c) begin
            if (!r) model_mem[a] = d;
            model_out = e.exp;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyModel(input logic c, input logic r, input logic [3:0] a,
                              input logic [3:0] d, input string name);
        logic [3:0] exp;
        exp = (!c && r) ? model_mem[a] : model_out;
        applyStimulus(c, r, a, d, exp, name);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
        model_out = 4'h0;
        sb_q.delete();
    endtask

    initial begin
        rst     = 1'b0;
        csn     = 1'b1;
        rwn     = 1'b1;
        addr    = 4'h0;
        data_in = 4'h0;
        clearModel();

        vecs[0] = '{1'b0, 1'b0, 4'd3,  4'hA, 4'h0, "wr3"};
        vecs[1] = '{1'b0, 1'b0, 4'd7,  4'h5, 4'h0, "wr7"};
        vecs[2] = '{1'b0, 1'b0, 4'd15, 4'hF, 4'h0, "wr15"};
        vecs[3] = '{1'b0, 1'b1, 4'd3,  4'h0, 4'hA, "rd3"};
        vecs[4] = '{1'b0, 1'b1, 4'd7,  4'h0, 4'h5, "rd7"};
        vecs[5] = '{1'b0, 1'b1, 4'd15, 4'h0, 4'hF, "rd15"};
        vecs[6] = '{1'b1, 1'b0, 4'd3,  4'h0, 4'hF, "inhibit_wr3"};
        vecs[7] = '{1'b0, 1'b1, 4'd3,  4'h0, 4'hA, "rd3_after_inhibit"};
        vecs[8] = '{1'b0, 1'b0, 4'd4,  4'h9, 4'hA, "wr4"};
        vecs[9] = '{1'b0, 1'b1, 4'd4,  4'h0, 4'h9, "rd4_after_wr"};

        // Reset held for two edges; data_out must be 0 throughout.
        #1 rst = 1'b1;
        #1 compare("reset_async", data_out, 4'h0);
        repeat (2) @(posedge clk);
        #1 compare("reset_held", data_out, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) applyModel(1'b0, 1'b1, 4'(i), 4'h0, "reset_read");

        foreach (vecs[i])
            applyStimulus(vecs[i].csn, vecs[i].rwn, vecs[i].addr, vecs[i].din, vecs[i].exp, vecs[i].name);

        applyModel(1'b1, 1'b1, 4'd9, 4'h3, "idle_hold");

        for (int i = 0; i < 16; i++) applyModel(1'b0, 1'b0, 4'(i), 4'(i), "sweep_wr");
        for (int i = 0; i < 16; i++) applyModel(1'b0, 1'b1, 4'(i), 4'h0, "sweep_rd");

        for (int i = 0; i < 16; i++) applyModel(1'b0, 1'b0, 4'(i), ~4'(i), "b2b_wr");
        applyStimulus(1'b0, 1'b1, 4'd0,  4'h0, 4'hF, "b2b_rd0");
        applyStimulus(1'b0, 1'b1, 4'd5,  4'h0, 4'hA, "b2b_rd5");
        applyStimulus(1'b0, 1'b1, 4'd15, 4'h0, 4'h0, "b2b_rd15");
        for (int i = 0; i < 16; i++) applyModel(1'b0, 1'b1, 4'(i), 4'h0, "b2b_rd");

        applyModel(1'b0, 1'b0, 4'd2, 4'h6, "wr2_6");
        applyStimulus(1'b0, 1'b1, 4'd0, 4'h0, 4'hF, "rd0_nonzero");

        // Reset arrives between edges while a write is pending; the write must be lost.
        @(negedge clk);
        csn     = 1'b0;
        rwn     = 1'b0;
        addr    = 4'd5;
        data_in = 4'h9;
        #2 rst = 1'b1;
        #1 compare("reset_mid_write", data_out, 4'h0);
        @(posedge clk);
        #1 compare("reset_edge_ignored", data_out, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        csn = 1'b1;
        clearModel();
        for (int i = 0; i < 16; i++) applyModel(1'b0, 1'b1, 4'(i), 4'h0, "post_reset_read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
